// File: rtl/sm_als_pkg.sv
// rtl/sm_als_pkg.sv - shared FSM encodings, default window size and read-word bit positions for sm_als_filter
package sm_als_pkg;

    typedef enum logic {
        ALS_FILL = 1'b0,
        ALS_RUN  = 1'b1
    } als_state_t;

    localparam int AVG_LOG2_DEF = 3;

    localparam int VALUE_VALID = 31;
    localparam int VALUE_DARK  = 30;
    localparam int VALUE_IRQ   = 29;

endpackage

// File: rtl/sm_als_window.sv
// rtl/sm_als_window.sv - ring buffer, running sum and fill counter producing the registered window average
import sm_als_pkg::*;

module sm_als_window #(
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic [15:0] avg,
    output logic        fill_done
);

    localparam int W  = 1 << AVG_LOG2;
    localparam int SW = 16 + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(W - 1);
    localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(W);

    logic [15:0]         ring [W];
    logic [AVG_LOG2-1:0] wptr;
    logic [SW-1:0]       sum;
    logic [SW-1:0]       sum_next;
    logic [AVG_LOG2:0]   fill_cnt;

    // Entries reset to zero, so subtracting the evicted slot is exact while filling.
    assign sum_next  = sum + SW'(in_data) - SW'(ring[wptr]);
    assign fill_done = in_valid && (fill_cnt == FILL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < W; i++) begin
                ring[i] <= '0;
            end
            wptr     <= '0;
            sum      <= '0;
            avg      <= '0;
            fill_cnt <= '0;
        end else if (in_valid) begin
            ring[wptr] <= in_data;
            wptr       <= wptr + 1'b1;
            sum        <= sum_next;
            avg        <= sum_next[AVG_LOG2 +: 16];
            if (fill_cnt != FILL_FULL) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_als_filter.sv
// rtl/sm_als_filter.sv - ALS moving average, hysteresis dark detector and sticky irq; irq logic under SM_ALS_IRQ_EN
import sm_als_pkg::*;

module sm_als_filter #(
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic [15:0] thr_lo,
    input  logic [15:0] thr_hi,
    input  logic        irq_ack,
    output logic [15:0] avg,
    output logic        avg_valid,
    output logic        dark,
    output logic        irq,
    output logic [31:0] value
);

    als_state_t state;
    als_state_t state_next;
    logic       fill_done;
    logic       dark_next;

    sm_als_window #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .avg       (avg),
        .fill_done (fill_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ALS_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ALS_FILL: if (fill_done) state_next = ALS_RUN;
            ALS_RUN:  state_next = ALS_RUN;
            default:  state_next = ALS_FILL;
        endcase
    end

    assign avg_valid = (state == ALS_RUN);

    // Set is tested first so an inverted threshold pair still resolves deterministically.
    always_comb begin
        dark_next = dark;
        if (avg_valid) begin
            if (avg < thr_lo) begin
                dark_next = 1'b1;
            end else if (avg > thr_hi) begin
                dark_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dark <= 1'b0;
        end else begin
            dark <= dark_next;
        end
    end

`ifdef SM_ALS_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (dark_next != dark) begin
            irq_q <= 1'b1;
        end else if (irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

    always_comb begin
        value              = '0;
        value[VALUE_VALID] = avg_valid;
        value[VALUE_DARK]  = dark;
        value[VALUE_IRQ]   = irq;
        value[15:0]        = avg;
    end

endmodule

// File: tb/tb_sm_als_filter.sv
// tb/tb_sm_als_filter.sv - directed self-checking bench for sm_als_filter with AVG_LOG2 = 2
module tb_sm_als_filter;

`ifdef SM_ALS_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic [15:0] thr_lo;
    logic [15:0] thr_hi;
    logic        irq_ack;
    logic [15:0] avg;
    logic        avg_valid;
    logic        dark;
    logic        irq;
    logic [31:0] value;

    int errors = 0;
    int checks = 0;

    sm_als_filter #(
        .AVG_LOG2 (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .thr_lo    (thr_lo),
        .thr_hi    (thr_hi),
        .irq_ack   (irq_ack),
        .avg       (avg),
        .avg_valid (avg_valid),
        .dark      (dark),
        .irq       (irq),
        .value     (value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic push4(input logic [15:0] d);
        for (int i = 0; i < 4; i++) push(d);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".avg"},       32'(avg),       32'd0);
        check({tag, ".avg_valid"}, 32'(avg_valid), 32'd0);
        check({tag, ".dark"},      32'(dark),      32'd0);
        check({tag, ".irq"},       32'(irq),       32'd0);
        check({tag, ".value"},     value,          32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        thr_lo   = 16'h0000;
        thr_hi   = 16'hFFFF;
        irq_ack  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        push(16'd100);
        push(16'd200);
        push(16'd300);
        check("fill3.avg_valid", 32'(avg_valid), 32'd0);
        check("fill3.avg",       32'(avg),       32'd150);
        push(16'd400);
        check("fill4.avg_valid", 32'(avg_valid), 32'd1);
        check("fill4.avg",       32'(avg),       32'd250);
        check("fill4.value",     value,          32'h8000_00FA);

        push(16'd800);
        check("slide.avg", 32'(avg), 32'd425);
        push(16'd0);
        push(16'd0);
        push(16'd0);
        check("zero3.avg", 32'(avg), 32'd200);
        push(16'd0);
        check("zero4.avg",  32'(avg),  32'd0);
        check("zero4.dark", 32'(dark), 32'd0);

        push4(16'h0900);
        thr_lo = 16'h0600;
        thr_hi = 16'h0800;
        @(negedge clk);
        check("high.avg",  32'(avg),  32'h0900);
        check("high.dark", 32'(dark), 32'd0);

        push(16'h0500);
        check("eq_hi.avg", 32'(avg), 32'h0800);
        push(16'h0500);
        push(16'h0500);
        check("eq_lo.avg", 32'(avg), 32'h0600);
        check("eq_lo.dark", 32'(dark), 32'd0);
        push(16'h0500);
        check("low.avg",       32'(avg),  32'h0500);
        check("low.dark_lag",  32'(dark), 32'd0);
        @(negedge clk);
        check("low.dark", 32'(dark), 32'd1);
        check("low.irq",  32'(irq),  32'(IRQ_EN));

        push4(16'h0700);
        @(negedge clk);
        check("mid.avg",  32'(avg),  32'h0700);
        check("mid.dark", 32'(dark), 32'd1);

        push(16'h0801);
        push(16'h0801);
        push(16'h0801);
        check("rise3.avg",  32'(avg),  32'h07C0);
        check("rise3.dark", 32'(dark), 32'd1);
        push(16'h0801);
        @(negedge clk);
        check("bright.dark",  32'(dark), 32'd0);
        check("bright.irq",   32'(irq),  32'(IRQ_EN));
        check("bright.value", value, {1'b1, 1'b0, IRQ_EN, 13'd0, 16'h0801});

        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("ack.irq",  32'(irq),  32'd0);
        check("ack.dark", 32'(dark), 32'd0);

        thr_lo  = 16'h0900;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("set_wins.dark",  32'(dark),     32'd1);
        check("set_wins.irq",   32'(irq),      32'(IRQ_EN));
        check("set_wins.v29",   32'(value[29]), 32'(IRQ_EN));
        @(negedge clk);
        check("sticky.irq", 32'(irq), 32'(IRQ_EN));

        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("lone_ack.irq",  32'(irq),  32'd0);
        check("lone_ack.dark", 32'(dark), 32'd1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("idle_ack.irq", 32'(irq), 32'd0);

        thr_lo = 16'h0000;
        thr_hi = 16'hFFFF;
        push(16'd10);
        push(16'd20);
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_rst");
        push(16'd40);
        push(16'd40);
        push(16'd40);
        check("refill3.avg_valid", 32'(avg_valid), 32'd0);
        check("refill3.avg",       32'(avg),       32'd30);
        push(16'd40);
        check("refill4.avg_valid", 32'(avg_valid), 32'd1);
        check("refill4.avg",       32'(avg),       32'd40);
        check("refill4.value",     value,          32'h8000_0028);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
